// File: rtl/vend_controller_if.sv
// Bus bundle between the vending controller and its coin acceptor, keypad,
// dispenser and change hopper. The master modport is the controller side.
interface vend_if #(
    parameter int CW = 5
);
    logic [1:0]    coin;
    logic          sel_valid;
    logic          sel;
    logic          cancel;
    logic          disp_req;
    logic          disp_item;
    logic          disp_ack;
    logic          change_ready;
    logic          change_out;
    logic          coin_reject;
    logic          sel_deny;
    logic [CW-1:0] credit;
    logic          busy;

    modport master (
        input  coin, sel_valid, sel, cancel, disp_ack, change_ready,
        output disp_req, disp_item, change_out, coin_reject, sel_deny, credit, busy
    );

    modport slave (
        output coin, sel_valid, sel, cancel, disp_ack, change_ready,
        input  disp_req, disp_item, change_out, coin_reject, sel_deny, credit, busy
    );
endinterface

// File: rtl/vend_controller.sv
// Two-product coin vending sequencer: collects credit, dispenses over a
// req/ack handshake, then pays change one nickel per hopper-ready cycle.
module vend_controller #(
    parameter int PRICE_A    = 3,
    parameter int PRICE_B    = 5,
    parameter int MAX_CREDIT = 15,
    parameter int CW         = 5
) (
    input  logic  clock_i,
    input  logic  reset_ni,
    vend_if.master bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_e;

    state_e        state_q,       state_d;
    logic [CW-1:0] credit_q,      credit_d;
    logic          disp_req_q,    disp_req_d;
    logic          disp_item_q,   disp_item_d;
    logic          change_out_q,  change_out_d;
    logic          coin_reject_q, coin_reject_d;
    logic          sel_deny_q,    sel_deny_d;
    logic          busy_q,        busy_d;

    logic [CW-1:0] coin_val;
    logic [CW-1:0] credit_sum;
    logic [CW-1:0] credit_base;
    logic [CW-1:0] price;
    logic          coin_present;
    logic          coin_fits;

    function automatic logic [CW-1:0] coin_value(input logic [1:0] code);
        case (code)
            2'b01:   return CW'(1);
            2'b10:   return CW'(2);
            2'b11:   return CW'(5);
            default: return CW'(0);
        endcase
    endfunction

    // CW holds MAX_CREDIT+5, so the trial sum never wraps before the check.
    function automatic logic credit_fits(input logic [CW-1:0] trial);
        return trial <= CW'(MAX_CREDIT);
    endfunction

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        disp_req_d    = disp_req_q;
        disp_item_d   = disp_item_q;
        change_out_d  = 1'b0;
        coin_reject_d = 1'b0;
        sel_deny_d    = 1'b0;

        coin_val     = coin_value(bus.coin);
        coin_present = (bus.coin != 2'b00);
        credit_sum   = credit_q + coin_val;
        coin_fits    = credit_fits(credit_sum);
        price        = bus.sel ? CW'(PRICE_B) : CW'(PRICE_A);
        credit_base  = credit_q;

        case (state_q)
            IDLE, COLLECT: begin
                if (state_q == COLLECT && bus.cancel) begin
                    // Refund wins over a same-cycle selection; any coin goes back.
                    state_d       = CHANGE;
                    coin_reject_d = coin_present;
                end else begin
                    if (bus.sel_valid) begin
                        if (state_q == COLLECT && credit_q >= price) begin
                            disp_item_d = bus.sel;
                            disp_req_d  = 1'b1;
                            state_d     = DISPENSE;
                            credit_base = credit_q - price;
                        end else begin
                            sel_deny_d = 1'b1;
                        end
                    end
                    // Coin acceptance is judged on the pre-purchase credit.
                    if (coin_present && !coin_fits) begin
                        coin_reject_d = 1'b1;
                        credit_d      = credit_base;
                    end else begin
                        credit_d = credit_base + coin_val;
                        if (coin_present && state_d != DISPENSE) begin
                            state_d = COLLECT;
                        end
                    end
                end
            end
            DISPENSE: begin
                coin_reject_d = coin_present;
                sel_deny_d    = bus.sel_valid;
                if (bus.disp_ack) begin
                    disp_req_d = 1'b0;
                    state_d    = (credit_q != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_present;
                sel_deny_d    = bus.sel_valid;
                if (bus.change_ready) begin
                    change_out_d = 1'b1;
                    credit_d     = credit_q - CW'(1);
                    if (credit_q == CW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                credit_d   = '0;
                disp_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d == DISPENSE) || (state_d == CHANGE);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            disp_req_q    <= 1'b0;
            disp_item_q   <= 1'b0;
            change_out_q  <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_deny_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            disp_req_q    <= disp_req_d;
            disp_item_q   <= disp_item_d;
            change_out_q  <= change_out_d;
            coin_reject_q <= coin_reject_d;
            sel_deny_q    <= sel_deny_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.disp_req    = disp_req_q;
    assign bus.disp_item   = disp_item_q;
    assign bus.change_out  = change_out_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.sel_deny    = sel_deny_q;
    assign bus.credit      = credit_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with a transaction-level credit model.
module tb_vend_controller;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_NICK = 2'b01;
    localparam logic [1:0] C_DIME = 2'b10;
    localparam logic [1:0] C_QUAR = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   npulse = 0;

    vend_if #(.CW(5)) vif();

    vend_controller #(
        .PRICE_A(3), .PRICE_B(5), .MAX_CREDIT(15), .CW(5)
    ) dut (
        .clock_i (clk),
        .reset_ni(rst_n),
        .bus     (vif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int credit;
        bit dispensing;
        bit paying;
        bit item;
        bit chg;
        bit rej;
        bit deny;
    } mdl_t;

    mdl_t m = '{default: 0};

    // Customer-level view: "collecting" is simply having credit while not busy.
    function automatic mdl_t model_next(input mdl_t c, input logic [1:0] coin,
                                        input logic sv, input logic s, input logic cn,
                                        input logic ak, input logic rd);
        mdl_t n;
        int   vals [4];
        int   val;
        int   price;
        bit   accepted;
        n = c;
        vals = '{0, 1, 2, 5};
        val = vals[coin];
        n.chg = 0; n.rej = 0; n.deny = 0;
        if (c.dispensing) begin
            n.rej = (coin != 0);
            n.deny = sv;
            if (ak) begin
                n.dispensing = 0;
                n.paying = (c.credit > 0);
            end
        end else if (c.paying) begin
            n.rej = (coin != 0);
            n.deny = sv;
            if (rd) begin
                n.credit = c.credit - 1;
                n.chg = 1;
                if (n.credit == 0) n.paying = 0;
            end
        end else if (c.credit > 0 && cn) begin
            n.paying = 1;
            n.rej = (coin != 0);
        end else begin
            accepted = (coin != 0) && (c.credit + val <= 15);
            n.rej = (coin != 0) && !accepted;
            if (sv) begin
                price = s ? 5 : 3;
                if (c.credit > 0 && c.credit >= price) begin
                    n.dispensing = 1;
                    n.item = s;
                    n.credit = c.credit - price;
                end else begin
                    n.deny = 1;
                end
            end
            if (accepted) n.credit = n.credit + val;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default: 0};
        else m <= model_next(m, vif.coin, vif.sel_valid, vif.sel, vif.cancel,
                             vif.disp_ack, vif.change_ready);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("disp_req",    int'(vif.disp_req),    int'(m.dispensing));
        chk("disp_item",   int'(vif.disp_item),   int'(m.item));
        chk("change_out",  int'(vif.change_out),  int'(m.chg));
        chk("coin_reject", int'(vif.coin_reject), int'(m.rej));
        chk("sel_deny",    int'(vif.sel_deny),    int'(m.deny));
        chk("credit",      int'(vif.credit),      m.credit);
        chk("busy",        int'(vif.busy),        int'(m.dispensing || m.paying));
    endtask

    task automatic step(input logic [1:0] c, input logic sv, input logic s,
                        input logic cn, input logic ak, input logic rd);
        vif.coin = c; vif.sel_valid = sv; vif.sel = s;
        vif.cancel = cn; vif.disp_ack = ak; vif.change_ready = rd;
        @(negedge clk);
        if (vif.change_out === 1'b1) npulse++;
        compare_all();
    endtask

    task automatic drain(input bit toggle, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (vif.busy !== 1'b1) break;
            step(C_NONE, 0, 0, 0, 0, toggle ? ((i % 2) == 0) : 1'b1);
        end
        chk("drain_done", int'(vif.busy), 0);
    endtask

    initial begin
        vif.coin = C_NONE; vif.sel_valid = 0; vif.sel = 0;
        vif.cancel = 0; vif.disp_ack = 0; vif.change_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_credit", int'(vif.credit), 0);
        chk("rst_req",    int'(vif.disp_req), 0);
        chk("rst_busy",   int'(vif.busy), 0);
        rst_n = 1'b1;
        step(C_NONE, 0, 0, 0, 0, 0);

        // Nickel + dime, buy A with exact credit.
        npulse = 0;
        step(C_NICK, 0, 0, 0, 0, 0);
        chk("s1_credit1", int'(vif.credit), 1);
        step(C_DIME, 0, 0, 0, 0, 0);
        chk("s1_credit3", int'(vif.credit), 3);
        step(C_NONE, 1, 0, 0, 0, 0);
        chk("s1_req", int'(vif.disp_req), 1);
        chk("s1_item", int'(vif.disp_item), 0);
        chk("s1_credit0", int'(vif.credit), 0);
        step(C_NONE, 0, 0, 0, 0, 0);
        step(C_NONE, 0, 0, 0, 0, 0);
        step(C_NONE, 0, 0, 0, 1, 0);
        chk("s1_req_drop", int'(vif.disp_req), 0);
        chk("s1_idle", int'(vif.busy), 0);
        step(C_NONE, 0, 0, 0, 0, 1);
        chk("s1_no_change", npulse, 0);

        // Quarter + dime, buy B, two nickels back.
        step(C_QUAR, 0, 0, 0, 0, 0);
        step(C_DIME, 0, 0, 0, 0, 0);
        chk("s2_credit7", int'(vif.credit), 7);
        step(C_NONE, 1, 1, 0, 0, 0);
        chk("s2_item", int'(vif.disp_item), 1);
        chk("s2_credit2", int'(vif.credit), 2);
        step(C_NONE, 0, 0, 0, 1, 0);
        chk("s2_busy", int'(vif.busy), 1);
        npulse = 0;
        step(C_NONE, 0, 0, 0, 0, 1);
        step(C_NONE, 0, 0, 0, 0, 1);
        chk("s2_pulses", npulse, 2);
        chk("s2_credit_end", int'(vif.credit), 0);
        chk("s2_idle", int'(vif.busy), 0);

        // Fill to max, overflow coin rejected, cancel refunds all 15.
        step(C_QUAR, 0, 0, 0, 0, 0);
        step(C_QUAR, 0, 0, 0, 0, 0);
        step(C_QUAR, 0, 0, 0, 0, 0);
        chk("s3_credit15", int'(vif.credit), 15);
        step(C_NICK, 0, 0, 0, 0, 0);
        chk("s3_reject", int'(vif.coin_reject), 1);
        chk("s3_credit_kept", int'(vif.credit), 15);
        step(C_NONE, 0, 0, 1, 0, 0);
        npulse = 0;
        drain(1'b1, 40);
        chk("s3_pulses", npulse, 15);
        chk("s3_credit_end", int'(vif.credit), 0);

        // Denied selections; same-cycle coin still counts.
        step(C_DIME, 0, 0, 0, 0, 0);
        step(C_NONE, 1, 1, 0, 0, 0);
        chk("s4_deny", int'(vif.sel_deny), 1);
        chk("s4_credit2", int'(vif.credit), 2);
        chk("s4_not_busy", int'(vif.busy), 0);
        step(C_QUAR, 1, 1, 0, 0, 0);
        chk("s4_deny2", int'(vif.sel_deny), 1);
        chk("s4_credit7", int'(vif.credit), 7);
        step(C_NONE, 0, 0, 1, 0, 0);
        drain(1'b0, 20);

        // Inputs during a long dispense.
        step(C_QUAR, 0, 0, 0, 0, 0);
        step(C_NONE, 1, 0, 0, 0, 0);
        chk("s5_credit2", int'(vif.credit), 2);
        step(C_DIME, 0, 0, 0, 0, 0);
        chk("s5_reject", int'(vif.coin_reject), 1);
        step(C_NONE, 1, 1, 0, 0, 0);
        chk("s5_deny", int'(vif.sel_deny), 1);
        step(C_NONE, 0, 0, 1, 0, 1);
        chk("s5_cancel_ign", int'(vif.disp_req), 1);
        repeat (10) step(C_NONE, 0, 0, 0, 0, 0);
        chk("s5_req_held", int'(vif.disp_req), 1);
        chk("s5_credit_held", int'(vif.credit), 2);
        step(C_NONE, 0, 0, 0, 1, 0);
        drain(1'b0, 10);

        // Cancel beats selection; async reset mid-refund.
        step(C_QUAR, 0, 0, 0, 0, 0);
        step(C_NICK, 1, 0, 1, 0, 0);
        chk("s6_cancel_rej", int'(vif.coin_reject), 1);
        chk("s6_no_deny", int'(vif.sel_deny), 0);
        chk("s6_no_disp", int'(vif.disp_req), 0);
        step(C_NONE, 0, 0, 0, 0, 1);
        chk("s6_credit4", int'(vif.credit), 4);
        step(C_NONE, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_credit", int'(vif.credit), 0);
        chk("s6_async_busy", int'(vif.busy), 0);
        chk("s6_async_chg", int'(vif.change_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(C_NICK, 0, 0, 0, 0, 0);
        chk("s6_resume", int'(vif.credit), 1);
        step(C_NONE, 0, 0, 1, 0, 0);
        drain(1'b0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Sequencing controller for a two-product coin vending point.
- Accumulates coin credit and accepts a product selection when credit covers the price.
- Drives a dispenser over a req/ack handshake, then pays change one nickel per accepted cycle.
- Sits between the coin acceptor, keypad, dispenser and change hopper.

Parameters:
- PRICE_A, 3, price of product A in nickel units (15c).
- PRICE_B, 5, price of product B in nickel units (25c).
- MAX_CREDIT, 15, maximum credit held, in nickel units (75c).
- CW, 5, credit register width; must hold MAX_CREDIT+5.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin  in  2  coin code, one coin per cycle: 00 none, 01 nickel (1), 10 dime (2), 11 quarter (5).
- sel_valid  in  1  selection strobe, one cycle.
- sel  in  1  product: 0=A, 1=B; valid with sel_valid.
- cancel  in  1  refund request, one cycle.
- disp_req  out  1  dispense request; held until ack.
- disp_item  out  1  product being dispensed; stable while disp_req=1.
- disp_ack  in  1  dispenser acknowledge.
- change_ready  in  1  hopper can accept a nickel this cycle.
- change_out  out  1  release one nickel this cycle.
- coin_reject  out  1  one-cycle pulse: the coin this cycle was not accepted and is diverted to return.
- sel_deny  out  1  one-cycle pulse: the selection was refused.
- credit  out  CW  current credit in nickel units.
- busy  out  1  high in DISPENSE or CHANGE.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; credit=0; disp_req, disp_item, change_out, coin_reject, sel_deny, busy all 0.
- All outputs are registered; each response appears the cycle after the input is sampled.
- States: IDLE (credit=0), COLLECT, DISPENSE, CHANGE.
- Coin in IDLE or COLLECT:
  - credit_next = credit + value.
  - If credit_next > MAX_CREDIT: pulse coin_reject; credit unchanged.
  - Otherwise credit is updated and the state moves to or stays in COLLECT.
- Coin in DISPENSE or CHANGE: pulse coin_reject; credit unchanged.
- sel_valid in COLLECT:
  - Compare the registered credit (before any same-cycle coin) against the price.
  - If credit >= price: disp_item <= sel; credit <= credit - price + accepted same-cycle coin; disp_req <= 1; go to DISPENSE.
  - Otherwise pulse sel_deny; the same-cycle coin is still processed normally.
- sel_valid in IDLE, DISPENSE or CHANGE: pulse sel_deny.
- cancel in COLLECT: go to CHANGE. cancel takes priority over a same-cycle sel_valid; that selection is ignored, with no sel_deny. A same-cycle coin is rejected.
- cancel in IDLE, DISPENSE or CHANGE: ignored.
- DISPENSE:
  - disp_req stays 1 until disp_ack is sampled high.
  - On the next cycle disp_req=0, and the state becomes CHANGE if credit>0, else IDLE.
  - disp_ack outside DISPENSE is ignored.
- CHANGE:
  - change_out = 1 in the cycle after each cycle where change_ready=1 is sampled; credit decrements by 1 with each change_out.
  - When the last nickel is issued (credit reaches 0), the state becomes IDLE in the same cycle.
  - Entered only with credit>0. Cancel with credit=0 is unreachable, because credit is always >0 in COLLECT.
- No wrap-around: credit never exceeds MAX_CREDIT and never goes below 0.
- Reset asserted mid-dispense or mid-change immediately clears all state. Any outstanding credit is lost.

Test Plan:
- Nickel, dime, then sel=0: credit 1→3; sel accepted; disp_req=1, disp_item=0, credit=0; ack after 3 cycles → disp_req drops the next cycle; IDLE; change_out never asserted.
- Quarter, dime, then sel=1: credit 7; dispense B; after ack, credit=2; with change_ready=1 continuously, two consecutive change_out pulses; credit=0; IDLE.
- Three quarters (credit 15), then a nickel: coin_reject pulses; credit stays 15. Then cancel with change_ready toggling 1/0: exactly 15 change_out pulses; IDLE.
- Dime, then sel=1 (needs 5): sel_deny pulses; state COLLECT; credit 2. Same-cycle quarter + sel=1 with credit 2: sel_deny pulses and credit becomes 7.
- During DISPENSE: a coin gives coin_reject; sel_valid gives sel_deny; cancel is ignored. disp_req held for 10 cycles without ack; credit unchanged.
- reset driven low asynchronously mid-CHANGE with credit 4: outputs clear before the next clock edge; credit=0; IDLE; normal operation resumes after reset is released.
